serial_fifo_ctrl: RTL and testbench

Buffered replacement for the CPU-facing serial controller: sits between the device controller's COM decode (enable/read/mode/data) and the 9600-baud `async_receiver`/`async_transmitter` pair. Received bytes are queued in an RX FIFO and transmitted bytes in a TX FIFO, so the CPU no longer loses input or spins per byte. A TX drain FSM feeds the transmitter one byte at a time; `int_o` goes to the CPU interrupt vector in the COM slot.

---
 rtl/serial_pkg.sv | 30 +++
 rtl/serial_fifo_ctrl_if.sv | 25 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/serial_fifo_ctrl.sv | 152 +++++++++++++++
 tb/tb_serial_fifo_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// serial_pkg : shared constants for the buffered COM serial controller
// Rev 1.0
// ------------------------------------------------------------------
package serial_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 16;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_GUARD = 2'd2;
  localparam logic [1:0] TX_DRAIN = 2'd3;

  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_TX_OVF       = 2;
  localparam int ST_RX_OVF       = 3;
  localparam int ST_TX_IDLE      = 4;
  localparam int ST_TX_DONE_IRQ  = 5;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_fifo_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// serial_fifo_ctrl_if : COM decode bus between CPU side and controller
// Rev 1.0
// ------------------------------------------------------------------
interface serial_fifo_ctrl_if;
  logic        enable_i;
  logic        readEnable_i;
  logic        mode_i;
  logic [31:0] dataSave_i;
  logic [31:0] dataLoad_o;
  logic        int_o;

  modport master (
    output enable_i, readEnable_i, mode_i, dataSave_i,
    input  dataLoad_o, int_o
  );

  modport slave (
    input  enable_i, readEnable_i, mode_i, dataSave_i,
    output dataLoad_o, int_o
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// sync_fifo : byte-wide show-ahead FIFO, count-based full/empty
// Rev 1.0
// ------------------------------------------------------------------
module sync_fifo #(
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    din_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          drop_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A pop frees a slot in the same edge, so a push into a full FIFO is kept
  // when it coincides with a pop; pointers wrap because depth is a power of two.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(FIFO_DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign drop_o  = push_i && !do_push;

endmodule
`default_nettype wire

// File: rtl/serial_fifo_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// serial_fifo_ctrl : CPU COM port with RX/TX FIFOs and TX drain FSM.
// Optional TX-done interrupt enabled by defining SERIAL_TX_INT_EN.
// Rev 1.0
// ------------------------------------------------------------------
module serial_fifo_ctrl
  import serial_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_fifo_ctrl_if.slave   bus,
  input  logic                rxdReady_i,
  input  logic [7:0]          rxdData_i,
  input  logic                txdBusy_i,
  output logic                txdStart_o,
  output logic [7:0]          txdData_o
);

  localparam int CW = count_width(FIFO_DEPTH);

  logic          data_acc, stat_rd, rx_pop, tx_push, tx_pop;
  logic [7:0]    rx_head, tx_head;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_full, rx_empty, rx_drop;
  logic          tx_full, tx_empty, tx_drop;
  logic [1:0]    state_q, state_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          tx_idle, tx_done_irq;
  logic [31:0]   status, load_data;
  logic          unused_save_bits;

  assign data_acc = bus.enable_i && !bus.mode_i;
  assign rx_pop   = data_acc && bus.readEnable_i;
  assign tx_push  = data_acc && !bus.readEnable_i;
  assign stat_rd  = bus.enable_i && bus.mode_i && bus.readEnable_i;
  assign tx_pop   = (state_q == TX_START);
  assign unused_save_bits = ^bus.dataSave_i[31:8];

  sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rxdReady_i),
    .din_i   (rxdData_i),
    .pop_i   (rx_pop),
    .head_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .drop_o  (rx_drop)
  );

  sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .din_i   (bus.dataSave_i[7:0]),
    .pop_i   (tx_pop),
    .head_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .drop_o  (tx_drop)
  );

  // GUARD gives the transmitter one cycle to raise busy after the start pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (!tx_empty && !txdBusy_i) state_d = TX_START;
      TX_START: state_d = TX_GUARD;
      TX_GUARD: state_d = TX_DRAIN;
      TX_DRAIN: if (!txdBusy_i) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  // A new overflow in the same cycle as a STATUS read survives the clear.
  always_comb begin
    tx_ovf_d = (tx_ovf_q && !stat_rd) || tx_drop;
    rx_ovf_d = (rx_ovf_q && !stat_rd) || rx_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TX_IDLE;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end

  assign tx_idle = tx_empty && (state_q == TX_IDLE);

`ifdef SERIAL_TX_INT_EN
  logic tx_idle_prev_q, tx_idle_prev_d;
  logic tx_done_irq_q, tx_done_irq_d;

  always_comb begin
    tx_idle_prev_d = tx_idle;
    tx_done_irq_d  = (tx_done_irq_q && !(stat_rd || tx_push)) || (tx_idle && !tx_idle_prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_idle_prev_q <= 1'b1;
      tx_done_irq_q  <= 1'b0;
    end else begin
      tx_idle_prev_q <= tx_idle_prev_d;
      tx_done_irq_q  <= tx_done_irq_d;
    end
  end

  assign tx_done_irq = tx_done_irq_q;
`else
  assign tx_done_irq = 1'b0;
`endif

  always_comb begin
    status                           = '0;
    status[ST_TX_NOT_FULL]           = !tx_full;
    status[ST_RX_NOT_EMPTY]          = !rx_empty;
    status[ST_TX_OVF]                = tx_ovf_q;
    status[ST_RX_OVF]                = rx_ovf_q;
    status[ST_TX_IDLE]               = tx_idle;
    status[ST_TX_DONE_IRQ]           = tx_done_irq;
    status[ST_RX_COUNT_LSB +: CW]    = rx_count;
    status[ST_TX_COUNT_LSB +: CW]    = tx_count;
  end

  always_comb begin
    load_data = '0;
    if (bus.enable_i && bus.readEnable_i) begin
      if (bus.mode_i)     load_data = status;
      else if (!rx_empty) load_data = {24'h0, rx_head};
    end
  end

  assign bus.dataLoad_o = load_data;
  assign bus.int_o      = !rx_empty || tx_done_irq;
  assign txdStart_o     = tx_pop;
  assign txdData_o      = tx_pop ? tx_head : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_serial_fifo_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// tb_serial_fifo_ctrl : directed bench with a 20-cycle transmitter model
// Rev 1.0
// ------------------------------------------------------------------
module tb_serial_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxdReady, txdBusy, txdStart;
  logic [7:0]  rxdData, txdData;
  logic        force_busy;
  int          busy_cnt = 0;
  int          busy_viol = 0;
  logic [7:0]  tx_log [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] d;

`ifdef SERIAL_TX_INT_EN
  localparam logic [31:0] IRQ    = 32'h20;
  localparam logic        IRQ_EN = 1'b1;
`else
  localparam logic [31:0] IRQ    = 32'h00;
  localparam logic        IRQ_EN = 1'b0;
`endif

  always #20 clk = ~clk;

  serial_fifo_ctrl_if bus ();

  serial_fifo_ctrl #(.FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .rxdReady_i (rxdReady),
    .rxdData_i  (rxdData),
    .txdBusy_i  (txdBusy),
    .txdStart_o (txdStart),
    .txdData_o  (txdData)
  );

  // Transmitter model: busy for 20 cycles after each start pulse.
  assign txdBusy = force_busy || (busy_cnt != 0);

  always @(negedge clk) begin
    if (txdStart) begin
      tx_log.push_back(txdData);
      if (txdBusy) busy_viol <= busy_viol + 1;
      busy_cnt <= 20;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < tx_log.size()) return 32'(tx_log[i]);
    return 32'hxxxx_xxxx;
  endfunction

  task automatic cycle(input logic en, input logic rd, input logic md, input logic [31:0] wd,
                       input logic rx, input logic [7:0] rxb, output logic [31:0] rdata);
    @(negedge clk);
    bus.enable_i     = en;
    bus.readEnable_i = rd;
    bus.mode_i       = md;
    bus.dataSave_i   = wd;
    rxdReady         = rx;
    rxdData          = rxb;
    #1 rdata = bus.dataLoad_o;
    @(posedge clk);
    #1;
    bus.enable_i = 1'b0;
    bus.readEnable_i = 1'b0;
    bus.mode_i = 1'b0;
    bus.dataSave_i = '0;
    rxdReady = 1'b0;
    rxdData = '0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    logic [31:0] t;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, b, t);
  endtask

  task automatic data_store(input logic [7:0] b);
    logic [31:0] t;
    cycle(1'b1, 1'b0, 1'b0, {24'hABCDEF, b}, 1'b0, 8'h00, t);
  endtask

  task automatic data_load(output logic [31:0] r);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00, r);
  endtask

  task automatic status_load(output logic [31:0] r);
    cycle(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 8'h00, r);
  endtask

  initial begin
    force_busy = 1'b0;
    rxdReady = 1'b0;
    rxdData = '0;
    bus.enable_i = 1'b0;
    bus.readEnable_i = 1'b0;
    bus.mode_i = 1'b0;
    bus.dataSave_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_dataLoad", bus.dataLoad_o, 32'h0);
    check("rst_int", 32'(bus.int_o), 32'h0);
    check("rst_txdStart", 32'(txdStart), 32'h0);
    check("rst_txdData", 32'(txdData), 32'h0);
    rst_n = 1'b1;
    status_load(d);
    check("rst_status", d, 32'h0000_0011);

    // Basic RX path
    rx_push(8'h41);
    rx_push(8'h42);
    status_load(d);
    check("rx2_status", d, 32'h0000_0213);
    check("rx2_int", 32'(bus.int_o), 32'h1);
    data_load(d);
    check("rx_load1", d, 32'h41);
    data_load(d);
    check("rx_load2", d, 32'h42);
    check("rx_int_clear", 32'(bus.int_o), 32'h0);
    data_load(d);
    check("rx_load_empty", d, 32'h0);

    // Basic TX path with 20-cycle busy
    tx_log.delete();
    data_store(8'h55);
    data_store(8'hAA);
    repeat (80) @(negedge clk);
    check("tx2_count", 32'(tx_log.size()), 32'd2);
    check("tx2_byte0", log_at(0), 32'h55);
    check("tx2_byte1", log_at(1), 32'hAA);
    check("tx2_busy_viol", 32'(busy_viol), 32'd0);
    status_load(d);
    check("tx2_status", d, 32'h0000_0011 | IRQ);

    // RX overflow
    for (int i = 1; i <= 17; i++) rx_push(8'(i));
    status_load(d);
    check("rxovf_status", d, 32'h0000_101B);
    status_load(d);
    check("rxovf_cleared", d, 32'h0000_1013);
    for (int i = 1; i <= 16; i++) begin
      data_load(d);
      check($sformatf("rxovf_load%0d", i), d, 32'(i));
    end
    check("rxovf_int", 32'(bus.int_o), 32'h0);

    // Full RX with simultaneous pop and push
    for (int i = 0; i < 16; i++) rx_push(8'(8'h60 + i));
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 8'h99, d);
    check("rxboth_load", d, 32'h60);
    status_load(d);
    check("rxboth_status", d, 32'h0000_1013);
    for (int i = 1; i < 16; i++) begin
      data_load(d);
      check($sformatf("rxboth_load%0d", i), d, 32'(8'h60 + i));
    end
    data_load(d);
    check("rxboth_last", d, 32'h99);
    data_load(d);
    check("rxboth_empty", d, 32'h0);

    // TX overflow with transmitter held busy
    force_busy = 1'b1;
    tx_log.delete();
    for (int i = 0; i < 17; i++) data_store(8'(8'h30 + i));
    status_load(d);
    check("txovf_status", d, 32'h0010_0004);
    check("txovf_no_start", 32'(tx_log.size()), 32'd0);
    force_busy = 1'b0;
    repeat (450) @(negedge clk);
    check("txovf_count", 32'(tx_log.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("txovf_byte%0d", i), log_at(i), 32'(8'h30 + i));
    check("txovf_busy_viol", 32'(busy_viol), 32'd0);
    status_load(d);
    check("txovf_end_status", d, 32'h0000_0011 | IRQ);

    // Reset during DRAIN
    tx_log.delete();
    rx_push(8'h5A);
    data_store(8'h01);
    data_store(8'h02);
    data_store(8'h03);
    @(negedge clk);
    @(negedge clk);
    check("rstd_started", 32'(tx_log.size()), 32'd1);
    check("rstd_int_pre", 32'(bus.int_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstd_int", 32'(bus.int_o), 32'h0);
    check("rstd_txdStart", 32'(txdStart), 32'h0);
    check("rstd_txdData", 32'(txdData), 32'h0);
    check("rstd_dataLoad", bus.dataLoad_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    status_load(d);
    check("rstd_status", d, 32'h0000_0011);
    data_load(d);
    check("rstd_rx_empty", d, 32'h0);
    repeat (60) @(negedge clk);
    check("rstd_no_start", 32'(tx_log.size()), 32'd1);

    // TX-done interrupt (absent in default build)
    data_store(8'h77);
    repeat (40) @(negedge clk);
    #1;
    check("txirq_int", 32'(bus.int_o), 32'(IRQ_EN));
    check("txirq_byte", log_at(1), 32'h77);
    status_load(d);
    check("txirq_status", d, 32'h0000_0011 | IRQ);
    check("txirq_int_clear", 32'(bus.int_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
